// File: rtl/gaus_log_tab_arb.sv
// Round-robin arbiter sharing the two read ports of gaus_log_tab among pN_REQ lanes.
// A tag pipeline in lock-step with the ROM routes each returned word to its owner.
module gaus_log_tab_arb #(
  parameter int pN_REQ  = 4,
  parameter int pADDR_W = 9,
  parameter int pDAT_W  = 18,
  parameter int pLAT    = 2
) (
  input  logic                      iclk,
  input  logic                      ireset,
  input  logic                      iclkena,
  input  logic [pN_REQ-1:0]         ireq_val,
  input  logic [pN_REQ*pADDR_W-1:0] ireq_addr,
  output logic [pN_REQ-1:0]         oreq_rdy,
  output logic [pADDR_W-1:0]        orom_addr0,
  output logic [pADDR_W-1:0]        orom_addr1,
  input  logic [pDAT_W-1:0]         irom_dat0,
  input  logic [pDAT_W-1:0]         irom_dat1,
  output logic [pN_REQ-1:0]         orsp_val,
  output logic [pN_REQ*pDAT_W-1:0]  orsp_dat,
  output logic                      obusy
);

  localparam int               IDX_W    = (pN_REQ > 1) ? $clog2(pN_REQ) : 1;
  localparam logic [IDX_W:0]   N_EXT    = (IDX_W+1)'(pN_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(pN_REQ - 1);

  logic [IDX_W-1:0]   rr_q;
  logic [IDX_W-1:0]   rr_d;
  logic [pADDR_W-1:0] addr_arr_s [pN_REQ];
  logic [IDX_W:0]     sum_s;
  logic [IDX_W-1:0]   idx_s;
  logic               hit_s;
  logic               g0_val_s;
  logic               g1_val_s;
  logic [IDX_W-1:0]   g0_id_s;
  logic [IDX_W-1:0]   g1_id_s;
  logic [IDX_W-1:0]   last_id_s;
  logic [pN_REQ-1:0]  rdy_s;

  logic               tv0_q  [pLAT];
  logic               tv1_q  [pLAT];
  logic [IDX_W-1:0]   tid0_q [pLAT];
  logic [IDX_W-1:0]   tid1_q [pLAT];

  logic [pN_REQ-1:0]  rsp_val_q;
  logic [pDAT_W-1:0]  rsp_dat_q [pN_REQ];
  logic               busy_s;

  for (genvar r = 0; r < pN_REQ; r++) begin : g_lane
    assign addr_arr_s[r]                 = ireq_addr[r*pADDR_W +: pADDR_W];
    assign orsp_dat[r*pDAT_W +: pDAT_W]  = rsp_dat_q[r];
  end

  // Scan lanes from the rr pointer; first active lane takes port0, second takes port1
  always_comb begin
    g0_val_s = 1'b0;
    g0_id_s  = '0;
    g1_val_s = 1'b0;
    g1_id_s  = '0;
    sum_s    = '0;
    idx_s    = '0;
    hit_s    = 1'b0;
    for (int k = 0; k < pN_REQ; k++) begin
      sum_s = {1'b0, rr_q} + (IDX_W+1)'(k);
      idx_s = (sum_s >= N_EXT) ? IDX_W'(sum_s - N_EXT) : sum_s[IDX_W-1:0];
      hit_s = iclkena & ireq_val[idx_s];
      if (hit_s && !g0_val_s) begin
        g0_val_s = 1'b1;
        g0_id_s  = idx_s;
      end else if (hit_s && !g1_val_s) begin
        g1_val_s = 1'b1;
        g1_id_s  = idx_s;
      end else begin
        hit_s = 1'b0;
      end
    end
  end

  // Grant vector, ROM addresses and next rr pointer derived from the two port grants
  always_comb begin
    rdy_s            = '0;
    rdy_s[g0_id_s]   = g0_val_s;
    rdy_s[g1_id_s]   = rdy_s[g1_id_s] | g1_val_s;
    orom_addr0       = g0_val_s ? addr_arr_s[g0_id_s] : '0;
    orom_addr1       = g1_val_s ? addr_arr_s[g1_id_s] : '0;
    last_id_s        = g1_val_s ? g1_id_s : g0_id_s;
    rr_d             = (last_id_s == LAST_IDX) ? '0 : last_id_s + IDX_W'(1);
  end

  assign oreq_rdy = rdy_s;

  // Round-robin pointer: moves just past the last lane granted
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      rr_q <= '0;
    end else if (iclkena && g0_val_s) begin
      rr_q <= rr_d;
    end
  end

  // Tag pipeline, advancing only with the ROM so tags line up with returned data
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      for (int s = 0; s < pLAT; s++) begin
        tv0_q[s]  <= 1'b0;
        tv1_q[s]  <= 1'b0;
        tid0_q[s] <= '0;
        tid1_q[s] <= '0;
      end
    end else if (iclkena) begin
      tv0_q[0]  <= g0_val_s;
      tv1_q[0]  <= g1_val_s;
      tid0_q[0] <= g0_id_s;
      tid1_q[0] <= g1_id_s;
      for (int s = 1; s < pLAT; s++) begin
        tv0_q[s]  <= tv0_q[s-1];
        tv1_q[s]  <= tv1_q[s-1];
        tid0_q[s] <= tid0_q[s-1];
        tid1_q[s] <= tid1_q[s-1];
      end
    end
  end

  // Response routing; ids of the two ports never collide, data of idle lanes holds
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      rsp_val_q <= '0;
      for (int r = 0; r < pN_REQ; r++) begin
        rsp_dat_q[r] <= '0;
      end
    end else if (iclkena) begin
      rsp_val_q <= '0;
      if (tv0_q[pLAT-1]) begin
        rsp_val_q[tid0_q[pLAT-1]] <= 1'b1;
        rsp_dat_q[tid0_q[pLAT-1]] <= irom_dat0;
      end
      if (tv1_q[pLAT-1]) begin
        rsp_val_q[tid1_q[pLAT-1]] <= 1'b1;
        rsp_dat_q[tid1_q[pLAT-1]] <= irom_dat1;
      end
    end
  end

  assign orsp_val = rsp_val_q;

  // Busy while any tag stage holds a valid read
  always_comb begin
    busy_s = 1'b0;
    for (int s = 0; s < pLAT; s++) begin
      busy_s = busy_s | tv0_q[s] | tv1_q[s];
    end
  end

  assign obusy = busy_s;

endmodule

// File: tb/tb_gaus_log_tab_arb.sv
// Directed and random bench for gaus_log_tab_arb with a behavioural 2-cycle ROM
// and a transaction-level model of grants, responses and busy.
module tb_gaus_log_tab_arb;
  localparam int N  = 4;
  localparam int AW = 9;
  localparam int DW = 18;

  logic            iclk = 1'b0;
  logic            ireset;
  logic            iclkena;
  logic [N-1:0]    ireq_val;
  logic [N*AW-1:0] ireq_addr;
  logic [N-1:0]    oreq_rdy;
  logic [AW-1:0]   orom_addr0, orom_addr1;
  logic [DW-1:0]   irom_dat0, irom_dat1;
  logic [DW-1:0]   rom0_p1, rom1_p1;
  logic [N-1:0]    orsp_val;
  logic [N*DW-1:0] orsp_dat;
  logic            obusy;

  int tests_run = 0;
  int fails     = 0;

  // model state
  logic [N-1:0]  val_m;
  logic [AW-1:0] addr_m [N];
  logic [DW-1:0] hold_m [N];
  int            wait_m [N];
  int            rr_m;
  int            E;
  bit            rand_mode;
  logic [N-1:0]  hs_val [int];
  logic [DW-1:0] hs_dat [int];

  gaus_log_tab_arb #(.pN_REQ(N), .pADDR_W(AW), .pDAT_W(DW), .pLAT(2)) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
    .ireq_val(ireq_val), .ireq_addr(ireq_addr), .oreq_rdy(oreq_rdy),
    .orom_addr0(orom_addr0), .orom_addr1(orom_addr1),
    .irom_dat0(irom_dat0), .irom_dat1(irom_dat1),
    .orsp_val(orsp_val), .orsp_dat(orsp_dat), .obusy(obusy)
  );

  always #5 iclk = ~iclk;

  // Stand-in for gaus_log_tab: real values at 0/1/2/511, arbitrary elsewhere
  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    case (a)
      9'd0:    return 18'd130950;
      9'd1:    return 18'd123460;
      9'd2:    return 18'd118861;
      9'd511:  return 18'd0;
      default: return {a, a} ^ 18'h2a5a5;
    endcase
  endfunction

  always @(posedge iclk) begin
    if (iclkena) begin
      rom0_p1   <= rom_f(orom_addr0);
      rom1_p1   <= rom_f(orom_addr1);
      irom_dat0 <= rom0_p1;
      irom_dat1 <= rom1_p1;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    ireq_val = val_m;
    for (int r = 0; r < N; r++) ireq_addr[r*AW +: AW] = addr_m[r];
  endtask

  task automatic model_grant(output logic [N-1:0] g, output int p0, output int p1);
    g = '0; p0 = -1; p1 = -1;
    if (iclkena) begin
      for (int k = 0; k < N; k++) begin
        int r;
        r = (rr_m + k) % N;
        if (val_m[r]) begin
          if (p0 < 0) p0 = r;
          else if (p1 < 0) p1 = r;
        end
      end
    end
    if (p0 >= 0) g[p0] = 1'b1;
    if (p1 >= 0) g[p1] = 1'b1;
  endtask

  // One clock: compare everything against the model, record handshakes, advance.
  task automatic cycle();
    logic [N-1:0]    g, ev;
    logic [N*DW-1:0] ed;
    logic [AW-1:0]   ea0, ea1;
    logic            eb;
    int p0, p1;
    #1;
    model_grant(g, p0, p1);
    ea0 = (p0 >= 0) ? addr_m[p0] : '0;
    ea1 = (p1 >= 0) ? addr_m[p1] : '0;
    check("rdy", 128'(oreq_rdy), 128'(g));
    check("addr0", 128'(orom_addr0), 128'(ea0));
    check("addr1", 128'(orom_addr1), 128'(ea1));
    ev = hs_val.exists(E-3) ? hs_val[E-3] : '0;
    for (int r = 0; r < N; r++) begin
      if (ev[r]) hold_m[r] = hs_dat[(E-3)*N + r];
      ed[r*DW +: DW] = hold_m[r];
    end
    eb = (hs_val.exists(E-1) && hs_val[E-1] != '0) || (hs_val.exists(E-2) && hs_val[E-2] != '0);
    check("rsp_val", 128'(orsp_val), 128'(ev));
    check("rsp_dat", 128'(orsp_dat), 128'(ed));
    check("busy", 128'(obusy), 128'(eb));
    if (iclkena) begin
      if (g != '0) begin
        hs_val[E] = g;
        for (int r = 0; r < N; r++) if (g[r]) hs_dat[E*N + r] = rom_f(addr_m[r]);
      end
      for (int r = 0; r < N; r++) begin
        if (val_m[r] && g[r]) begin
          check("grant_wait", 128'(wait_m[r] <= 1), 128'd1);
          wait_m[r] = 0;
        end else if (val_m[r]) begin
          wait_m[r]++;
        end
      end
      if (p1 >= 0) rr_m = (p1 + 1) % N;
      else if (p0 >= 0) rr_m = (p0 + 1) % N;
    end
    @(posedge iclk);
    if (iclkena) E++;
    #1;
    val_m = val_m & ~g;
    if (rand_mode) begin
      for (int r = 0; r < N; r++) begin
        if (!val_m[r] && $urandom_range(99) < 50) begin
          val_m[r]  = 1'b1;
          addr_m[r] = AW'($urandom_range(511));
        end
      end
      iclkena = ($urandom_range(99) < 85);
    end
    apply();
  endtask

  task automatic do_reset();
    ireset = 1'b0;
    val_m  = '0;
    apply();
    #1;
    check("rst_rsp_val", 128'(orsp_val), 128'd0);
    check("rst_rsp_dat", 128'(orsp_dat), 128'd0);
    check("rst_busy", 128'(obusy), 128'd0);
    hs_val.delete();
    hs_dat.delete();
    rr_m = 0;
    for (int r = 0; r < N; r++) begin
      hold_m[r] = '0;
      wait_m[r] = 0;
    end
    repeat (2) @(posedge iclk);
    #1;
    ireset = 1'b1;
  endtask

  initial begin
    ireset = 1'b0; iclkena = 1'b1; rand_mode = 1'b0; E = 0; rr_m = 0;
    val_m = '0; ireq_val = '0; ireq_addr = '0;
    for (int r = 0; r < N; r++) begin
      addr_m[r] = '0; hold_m[r] = '0; wait_m[r] = 0;
    end
    do_reset();

    // 1: single read from lane0, address 0
    val_m = 4'b0001; addr_m[0] = 9'd0; apply(); #1;
    check("t1_rdy", 128'(oreq_rdy), 128'(4'b0001));
    check("t1_addr0", 128'(orom_addr0), 128'd0);
    check("t1_addr1", 128'(orom_addr1), 128'd0);
    cycle(); cycle(); cycle(); #1;
    check("t1_rsp_val", 128'(orsp_val), 128'(4'b0001));
    check("t1_rsp_dat0", 128'(orsp_dat[DW-1:0]), 128'd130950);
    cycle();

    // 2: all lanes request continuously
    do_reset();
    addr_m[0] = 9'd0; addr_m[1] = 9'd1; addr_m[2] = 9'd2; addr_m[3] = 9'd511;
    for (int i = 0; i < 6; i++) begin
      val_m = 4'b1111; apply(); #1;
      check("t2_rdy", 128'(oreq_rdy), (i % 2 == 0) ? 128'(4'b0011) : 128'(4'b1100));
      cycle();
    end
    val_m = '0; apply();
    repeat (4) cycle();
    #1;
    check("t2_dat", 128'(orsp_dat), 128'({18'd0, 18'd118861, 18'd123460, 18'd130950}));
    check("t2_busy", 128'(obusy), 128'd0);

    // 3: wrap-around order with rr=2
    do_reset();
    val_m = 4'b0011; addr_m[0] = 9'd5; addr_m[1] = 9'd6; apply(); cycle();
    val_m = 4'b1010; addr_m[1] = 9'd7; addr_m[3] = 9'd9; apply(); #1;
    check("t3_rdy", 128'(oreq_rdy), 128'(4'b1010));
    check("t3_addr0", 128'(orom_addr0), 128'd9);
    check("t3_addr1", 128'(orom_addr1), 128'd7);
    cycle();
    val_m = 4'b1101; addr_m[2] = 9'd10; apply(); #1;
    check("t3_rr2", 128'(oreq_rdy), 128'(4'b1100));
    cycle();
    repeat (5) cycle();
    #1;
    check("t3_dat3", 128'(orsp_dat[3*DW +: DW]), 128'(rom_f(9'd9)));
    check("t3_dat1", 128'(orsp_dat[1*DW +: DW]), 128'(rom_f(9'd7)));

    // 4: stall with reads in flight
    val_m = 4'b0101; addr_m[0] = 9'd20; addr_m[2] = 9'd30; apply(); cycle();
    iclkena = 1'b0; val_m[1] = 1'b1; addr_m[1] = 9'd40; apply();
    repeat (5) begin
      #1;
      check("t4_rdy_stall", 128'(oreq_rdy), 128'd0);
      check("t4_busy_stall", 128'(obusy), 128'd1);
      cycle();
    end
    iclkena = 1'b1; apply();
    cycle(); cycle(); #1;
    check("t4_rsp_val", 128'(orsp_val), 128'(4'b0101));
    check("t4_dat0", 128'(orsp_dat[0 +: DW]), 128'(rom_f(9'd20)));
    check("t4_dat2", 128'(orsp_dat[2*DW +: DW]), 128'(rom_f(9'd30)));
    repeat (4) cycle();

    // 5: reset with four reads in flight
    val_m = 4'b1111;
    for (int r = 0; r < N; r++) addr_m[r] = AW'(100 + r);
    apply(); cycle(); cycle(); #1;
    check("t5_busy_pre", 128'(obusy), 128'd1);
    do_reset();
    repeat (6) cycle();
    #1;
    check("t5_no_rsp", 128'(orsp_val), 128'd0);

    // 6: random traffic with random stalls
    rand_mode = 1'b1;
    repeat (10000) cycle();
    rand_mode = 1'b0; iclkena = 1'b1; apply();
    repeat (12) cycle();
    #1;
    check("t6_drained", 128'(obusy), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
